// File: rtl/axi_ic_pkg.sv
// Shared AXI interconnect constants: AW sideband field widths, arbitration modes, index-width helper.
// Pure declarations; no latency or backpressure of its own.
package axi_ic_pkg;
    localparam int AW_SIZE_W  = 3;
    localparam int AW_BURST_W = 2;
    localparam int AW_LOCK_W  = 2;
    localparam int AW_CACHE_W = 4;
    localparam int AW_PROT_W  = 3;
    localparam int AW_QOS_W   = 4;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/aw_arb_mux_n_if.sv
// N-master AW bundle: packed per-master inputs, one registered slave-side output, grant/done reporting.
// Wires only; the slave modport is the arbiter's view, master is the surrounding fabric's view.
interface aw_arb_mux_n_if #(
    parameter int NUM_MASTERS   = 4,
    parameter int Address_width = 32,
    parameter int S_Aw_len      = 8,
    parameter int IDX_W         = $clog2(NUM_MASTERS)
) ();
    import axi_ic_pkg::*;

    logic [NUM_MASTERS*Address_width-1:0] S_AXI_awaddr;
    logic [NUM_MASTERS*S_Aw_len-1:0]      S_AXI_awlen;
    logic [NUM_MASTERS*AW_SIZE_W-1:0]     S_AXI_awsize;
    logic [NUM_MASTERS*AW_BURST_W-1:0]    S_AXI_awburst;
    logic [NUM_MASTERS*AW_LOCK_W-1:0]     S_AXI_awlock;
    logic [NUM_MASTERS*AW_CACHE_W-1:0]    S_AXI_awcache;
    logic [NUM_MASTERS*AW_PROT_W-1:0]     S_AXI_awprot;
    logic [NUM_MASTERS*AW_QOS_W-1:0]      S_AXI_awqos;
    logic [NUM_MASTERS-1:0]               S_AXI_awvalid;
    logic [NUM_MASTERS-1:0]               S_AXI_awready;

    logic [Address_width-1:0] M_AXI_awaddr;
    logic [S_Aw_len-1:0]      M_AXI_awlen;
    logic [AW_SIZE_W-1:0]     M_AXI_awsize;
    logic [AW_BURST_W-1:0]    M_AXI_awburst;
    logic [AW_LOCK_W-1:0]     M_AXI_awlock;
    logic [AW_CACHE_W-1:0]    M_AXI_awcache;
    logic [AW_PROT_W-1:0]     M_AXI_awprot;
    logic [AW_QOS_W-1:0]      M_AXI_awqos;
    logic                     M_AXI_awvalid;
    logic                     M_AXI_awready;

    logic [IDX_W-1:0] M_grant_idx;
    logic             aw_done;
    logic [IDX_W-1:0] aw_done_idx;

    modport slave (
        input  S_AXI_awaddr, S_AXI_awlen, S_AXI_awsize, S_AXI_awburst, S_AXI_awlock,
               S_AXI_awcache, S_AXI_awprot, S_AXI_awqos, S_AXI_awvalid, M_AXI_awready,
        output S_AXI_awready, M_AXI_awaddr, M_AXI_awlen, M_AXI_awsize, M_AXI_awburst,
               M_AXI_awlock, M_AXI_awcache, M_AXI_awprot, M_AXI_awqos, M_AXI_awvalid,
               M_grant_idx, aw_done, aw_done_idx
    );

    modport master (
        output S_AXI_awaddr, S_AXI_awlen, S_AXI_awsize, S_AXI_awburst, S_AXI_awlock,
               S_AXI_awcache, S_AXI_awprot, S_AXI_awqos, S_AXI_awvalid, M_AXI_awready,
        input  S_AXI_awready, M_AXI_awaddr, M_AXI_awlen, M_AXI_awsize, M_AXI_awburst,
               M_AXI_awlock, M_AXI_awcache, M_AXI_awprot, M_AXI_awqos, M_AXI_awvalid,
               M_grant_idx, aw_done, aw_done_idx
    );
endinterface

// File: rtl/rr_arbiter.sv
// N-way one-hot arbiter, round-robin from rr_ptr or fixed lowest-index priority; shared by AW and AR.
// Grant is combinational from req_vld; rr_ptr moves to winner+1 only when adv_en is high.
module rr_arbiter
    import axi_ic_pkg::*;
#(
    parameter int N    = 4,
    parameter int MODE = ARB_RR,
    localparam int IW  = clog2_min1(N)
) (
    input  logic          core_clk,
    input  logic          arst,
    input  logic [N-1:0]  req_vld,
    input  logic          adv_en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_req
);
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] nxt_ptr;

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (MODE == ARB_FIXED) ? k : int'(rr_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!any_req && req_vld[idx]) begin
                any_req    = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

    // Explicit compare so non-power-of-2 N wraps correctly.
    assign nxt_ptr = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge core_clk or posedge arst) begin
        if (arst) begin
            rr_ptr <= '0;
        end else if (MODE != ARB_FIXED && adv_en && any_req) begin
            rr_ptr <= nxt_ptr;
        end
    end
endmodule

// File: rtl/aw_arb_mux_n.sv
// N:1 AXI4 AW arbiter/mux with a one-deep output register and grant/done reporting for W steering.
// Latency: 1 cycle accept to M_AXI_awvalid; backpressure: S_AXI_awready only when the register is free.
module aw_arb_mux_n
    import axi_ic_pkg::*;
#(
    parameter int NUM_MASTERS   = 4,
    parameter int Address_width = 32,
    parameter int S_Aw_len      = 8,
    parameter int ARB_MODE      = ARB_RR,
    parameter int IDX_W         = $clog2(NUM_MASTERS)
) (
    input  logic             ACLK,
    input  logic             ARESET,
    aw_arb_mux_n_if.slave    aw
);
    logic [NUM_MASTERS-1:0] grant;
    logic [IDX_W-1:0]       win_idx;
    logic                   any_req;
    logic                   out_free;
    logic                   accept;
    logic                   hs;

    assign out_free = !aw.M_AXI_awvalid || aw.M_AXI_awready;
    assign accept   = out_free && any_req && !ARESET;
    assign hs       = aw.M_AXI_awvalid && aw.M_AXI_awready;

    // Ready is held low while reset is asserted even though the empty register looks free.
    assign aw.S_AXI_awready = (out_free && !ARESET) ? grant : '0;

    rr_arbiter #(
        .N    (NUM_MASTERS),
        .MODE (ARB_MODE)
    ) u_arb (
        .core_clk  (ACLK),
        .arst      (ARESET),
        .req_vld   (aw.S_AXI_awvalid),
        .adv_en    (accept),
        .grant     (grant),
        .grant_idx (win_idx),
        .any_req   (any_req)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw.M_AXI_awvalid <= 1'b0;
            aw.M_AXI_awaddr  <= '0;
            aw.M_AXI_awlen   <= '0;
            aw.M_AXI_awsize  <= '0;
            aw.M_AXI_awburst <= '0;
            aw.M_AXI_awlock  <= '0;
            aw.M_AXI_awcache <= '0;
            aw.M_AXI_awprot  <= '0;
            aw.M_AXI_awqos   <= '0;
            aw.M_grant_idx   <= '0;
            aw.aw_done       <= 1'b0;
            aw.aw_done_idx   <= '0;
        end else begin
            aw.aw_done <= hs;
            if (hs) aw.aw_done_idx <= aw.M_grant_idx;
            if (out_free) aw.M_AXI_awvalid <= any_req;
            if (accept) begin
                aw.M_AXI_awaddr  <= aw.S_AXI_awaddr [int'(win_idx)*Address_width +: Address_width];
                aw.M_AXI_awlen   <= aw.S_AXI_awlen  [int'(win_idx)*S_Aw_len      +: S_Aw_len];
                aw.M_AXI_awsize  <= aw.S_AXI_awsize [int'(win_idx)*AW_SIZE_W     +: AW_SIZE_W];
                aw.M_AXI_awburst <= aw.S_AXI_awburst[int'(win_idx)*AW_BURST_W    +: AW_BURST_W];
                aw.M_AXI_awlock  <= aw.S_AXI_awlock [int'(win_idx)*AW_LOCK_W     +: AW_LOCK_W];
                aw.M_AXI_awcache <= aw.S_AXI_awcache[int'(win_idx)*AW_CACHE_W    +: AW_CACHE_W];
                aw.M_AXI_awprot  <= aw.S_AXI_awprot [int'(win_idx)*AW_PROT_W     +: AW_PROT_W];
                aw.M_AXI_awqos   <= aw.S_AXI_awqos  [int'(win_idx)*AW_QOS_W      +: AW_QOS_W];
                aw.M_grant_idx   <= win_idx;
            end
        end
    end
endmodule

// File: tb/tb_aw_arb_mux_n.sv
// Drives a round-robin and a fixed-priority instance with identical stimulus and compares both
// against a cycle-level reference model of the arbitration/register rules.
module tb_aw_arb_mux_n;
    import axi_ic_pkg::*;

    localparam int N = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [1:0]  lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
    } pay_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pay_t           in_pay [N];
    logic [N-1:0]   in_vld;
    logic           m_rdy;

    logic [N*32-1:0] s_awaddr;
    logic [N*8-1:0]  s_awlen;
    logic [N*3-1:0]  s_awsize;
    logic [N*2-1:0]  s_awburst;
    logic [N*2-1:0]  s_awlock;
    logic [N*4-1:0]  s_awcache;
    logic [N*3-1:0]  s_awprot;
    logic [N*4-1:0]  s_awqos;

    always_comb begin
        s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0;
        s_awlock = '0; s_awcache = '0; s_awprot = '0; s_awqos = '0;
        for (int i = 0; i < N; i++) begin
            s_awaddr [i*32 +: 32] = in_pay[i].addr;
            s_awlen  [i*8  +: 8]  = in_pay[i].len;
            s_awsize [i*3  +: 3]  = in_pay[i].size;
            s_awburst[i*2  +: 2]  = in_pay[i].burst;
            s_awlock [i*2  +: 2]  = in_pay[i].lock;
            s_awcache[i*4  +: 4]  = in_pay[i].cache;
            s_awprot [i*3  +: 3]  = in_pay[i].prot;
            s_awqos  [i*4  +: 4]  = in_pay[i].qos;
        end
    end

    aw_arb_mux_n_if #(.NUM_MASTERS(N)) if_rr ();
    aw_arb_mux_n_if #(.NUM_MASTERS(N)) if_fx ();

    assign if_rr.S_AXI_awaddr = s_awaddr;   assign if_fx.S_AXI_awaddr = s_awaddr;
    assign if_rr.S_AXI_awlen = s_awlen;     assign if_fx.S_AXI_awlen = s_awlen;
    assign if_rr.S_AXI_awsize = s_awsize;   assign if_fx.S_AXI_awsize = s_awsize;
    assign if_rr.S_AXI_awburst = s_awburst; assign if_fx.S_AXI_awburst = s_awburst;
    assign if_rr.S_AXI_awlock = s_awlock;   assign if_fx.S_AXI_awlock = s_awlock;
    assign if_rr.S_AXI_awcache = s_awcache; assign if_fx.S_AXI_awcache = s_awcache;
    assign if_rr.S_AXI_awprot = s_awprot;   assign if_fx.S_AXI_awprot = s_awprot;
    assign if_rr.S_AXI_awqos = s_awqos;     assign if_fx.S_AXI_awqos = s_awqos;
    assign if_rr.S_AXI_awvalid = in_vld;    assign if_fx.S_AXI_awvalid = in_vld;
    assign if_rr.M_AXI_awready = m_rdy;     assign if_fx.M_AXI_awready = m_rdy;

    aw_arb_mux_n #(.NUM_MASTERS(N), .ARB_MODE(ARB_RR))    u_rr (.ACLK(clk), .ARESET(rst), .aw(if_rr.slave));
    aw_arb_mux_n #(.NUM_MASTERS(N), .ARB_MODE(ARB_FIXED)) u_fx (.ACLK(clk), .ARESET(rst), .aw(if_fx.slave));

    // Observed outputs, index 0 = round-robin instance, 1 = fixed-priority instance.
    logic [N-1:0] o_rdy  [2];
    logic         o_vld  [2];
    pay_t         o_pay  [2];
    logic [1:0]   o_gidx [2];
    logic         o_done [2];
    logic [1:0]   o_didx [2];

    assign o_rdy[0] = if_rr.S_AXI_awready;  assign o_rdy[1] = if_fx.S_AXI_awready;
    assign o_vld[0] = if_rr.M_AXI_awvalid;  assign o_vld[1] = if_fx.M_AXI_awvalid;
    assign o_pay[0] = {if_rr.M_AXI_awaddr, if_rr.M_AXI_awlen, if_rr.M_AXI_awsize, if_rr.M_AXI_awburst,
                       if_rr.M_AXI_awlock, if_rr.M_AXI_awcache, if_rr.M_AXI_awprot, if_rr.M_AXI_awqos};
    assign o_pay[1] = {if_fx.M_AXI_awaddr, if_fx.M_AXI_awlen, if_fx.M_AXI_awsize, if_fx.M_AXI_awburst,
                       if_fx.M_AXI_awlock, if_fx.M_AXI_awcache, if_fx.M_AXI_awprot, if_fx.M_AXI_awqos};
    assign o_gidx[0] = if_rr.M_grant_idx;   assign o_gidx[1] = if_fx.M_grant_idx;
    assign o_done[0] = if_rr.aw_done;       assign o_done[1] = if_fx.aw_done;
    assign o_didx[0] = if_rr.aw_done_idx;   assign o_didx[1] = if_fx.aw_done_idx;

    // Reference model state.
    pay_t e_pay  [2];
    bit   e_vld  [2];
    int   e_gidx [2];
    bit   e_done [2];
    int   e_didx [2];
    int   e_ptr  [2];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic pay_t rand_pay();
        pay_t p;
        p.addr  = $urandom;
        p.len   = 8'($urandom_range(0, 255));
        p.size  = 3'($urandom_range(0, 7));
        p.burst = 2'($urandom_range(0, 3));
        p.lock  = 2'($urandom_range(0, 3));
        p.cache = 4'($urandom_range(0, 15));
        p.prot  = 3'($urandom_range(0, 7));
        p.qos   = 4'($urandom_range(0, 15));
        return p;
    endfunction

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            e_pay[m] = '0; e_vld[m] = 0; e_gidx[m] = 0;
            e_done[m] = 0; e_didx[m] = 0; e_ptr[m] = 0;
        end
    endfunction

    // Round-robin: first valid scanning upward from the pointer with wrap; fixed: lowest valid.
    function automatic int winner(input int m);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m == 0) ? (e_ptr[m] + k) % N : k;
            if (in_vld[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic drive(input logic [N-1:0] v, input bit r);
        in_vld = v;
        m_rdy  = r;
        for (int i = 0; i < N; i++) in_pay[i] = rand_pay();
        #1;
    endtask

    // Compare both instances against the model, advance the model by one edge, go to next negedge.
    task automatic step();
        string    nm;
        int       w;
        bit       free;
        logic [N-1:0] er;
        for (int m = 0; m < 2; m++) begin
            nm   = (m == 0) ? "rr" : "fx";
            w    = winner(m);
            free = !e_vld[m] || m_rdy;
            er   = (free && w >= 0) ? (N'(1) << w) : '0;
            chk({nm, " awready"}, 64'(o_rdy[m]), 64'(er));
            chk({nm, " m_awvalid"}, 64'(o_vld[m]), 64'(e_vld[m]));
            chk({nm, " payload"}, 64'(o_pay[m]), 64'(e_pay[m]));
            chk({nm, " grant_idx"}, 64'(o_gidx[m]), 64'(e_gidx[m]));
            chk({nm, " aw_done"}, 64'(o_done[m]), 64'(e_done[m]));
            if (e_done[m]) chk({nm, " aw_done_idx"}, 64'(o_didx[m]), 64'(e_didx[m]));
            e_done[m] = e_vld[m] && m_rdy;
            if (e_done[m]) e_didx[m] = e_gidx[m];
            if (free) begin
                if (w >= 0) begin
                    e_vld[m]  = 1;
                    e_pay[m]  = in_pay[w];
                    e_gidx[m] = w;
                    if (m == 0) e_ptr[m] = (w + 1) % N;
                end else begin
                    e_vld[m] = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] exp_oh;
        rst    = 1'b1;
        in_vld = '0;
        m_rdy  = 1'b0;
        for (int i = 0; i < N; i++) in_pay[i] = '0;
        #12;
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Reset state.
        drive('0, 1'b1); step();

        // Single master S1.
        do_reset();
        drive(4'b0010, 1'b1);
        in_pay[1].addr = 32'h1000_0040;
        in_pay[1].len  = 8'd7;
        #1;
        chk("single awready", 64'(if_rr.S_AXI_awready), 64'(4'b0010));
        step();
        drive('0, 1'b1);
        chk("single m_awvalid", 64'(if_rr.M_AXI_awvalid), 64'(1));
        chk("single m_awaddr", 64'(if_rr.M_AXI_awaddr), 64'(32'h1000_0040));
        chk("single m_awlen", 64'(if_rr.M_AXI_awlen), 64'(7));
        step();
        drive('0, 1'b1);
        chk("single aw_done", 64'(if_rr.aw_done), 64'(1));
        chk("single aw_done_idx", 64'(if_rr.aw_done_idx), 64'(1));
        step();

        // Round-robin fairness, full throughput.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(4'b1111, 1'b1);
            exp_oh = N'(1) << (k % N);
            chk($sformatf("rr order %0d", k), 64'(if_rr.S_AXI_awready), 64'(exp_oh));
            if (k > 0) chk($sformatf("rr stream vld %0d", k), 64'(if_rr.M_AXI_awvalid), 64'(1));
            step();
        end

        // Stall with S2/S3 valid.
        do_reset();
        drive(4'b1100, 1'b1); step();
        for (int k = 0; k < 5; k++) begin
            drive(4'b1100, 1'b0);
            chk($sformatf("stall awready %0d", k), 64'(if_rr.S_AXI_awready), 64'(0));
            chk($sformatf("stall grant_idx %0d", k), 64'(if_rr.M_grant_idx), 64'(2));
            step();
        end
        drive(4'b1100, 1'b1);
        chk("stall release grant", 64'(if_rr.S_AXI_awready), 64'(4'b1000));
        step();

        // Fixed priority: S1 starves S3 until it drops.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(4'b1010, 1'b1);
            chk($sformatf("fixed s1 %0d", k), 64'(if_fx.S_AXI_awready), 64'(4'b0010));
            step();
        end
        drive(4'b1000, 1'b1);
        chk("fixed s3 after drop", 64'(if_fx.S_AXI_awready), 64'(4'b1000));
        step();

        // Wrap 3 -> 0 back-to-back.
        do_reset();
        drive(4'b0100, 1'b1); step();
        drive(4'b1001, 1'b1);
        chk("wrap grant 3", 64'(if_rr.S_AXI_awready), 64'(4'b1000));
        step();
        drive(4'b1001, 1'b1);
        chk("wrap grant 0", 64'(if_rr.S_AXI_awready), 64'(4'b0001));
        chk("wrap no bubble", 64'(if_rr.M_AXI_awvalid), 64'(1));
        step();
        drive('0, 1'b1);
        chk("wrap held idx", 64'(if_rr.M_grant_idx), 64'(0));
        step();

        // Async reset while stalled.
        do_reset();
        drive(4'b1111, 1'b1); step();
        drive(4'b1111, 1'b0); step();
        drive(4'b1111, 1'b0);
        rst = 1'b1;
        #1;
        chk("arst rr m_awvalid", 64'(if_rr.M_AXI_awvalid), 64'(0));
        chk("arst fx m_awvalid", 64'(if_fx.M_AXI_awvalid), 64'(0));
        chk("arst rr awready", 64'(if_rr.S_AXI_awready), 64'(0));
        chk("arst fx awready", 64'(if_fx.S_AXI_awready), 64'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(4'b1111, 1'b1);
        chk("arst first grant", 64'(if_rr.S_AXI_awready), 64'(4'b0001));
        step();

        // Randomized traffic.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            drive(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            step();
        end
        drive('0, 1'b1); step();
        drive('0, 1'b1); step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/aw_arb_mux_n.md
Name: aw_arb_mux_n

Overview:
- N-input AXI4 write-address channel arbiter and multiplexer with a registered output stage.
- Sits in the interconnect datapath between N master-side AW ports and one slave-side AW port.
- Replaces the 2:1 combinational select with internal arbitration, per-input awready back-pressure and a one-deep output register.
- Reports the granted index so the W-channel mux can be steered.

Parameters:
- NUM_MASTERS, 4, number of AW inputs; legal values are 2..16.
- Address_width, 32, awaddr width.
- S_Aw_len, 8, awlen width (AXI4).
- ARB_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
- IDX_W, $clog2(NUM_MASTERS), width of the grant index.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_awaddr  in  NUM_MASTERS*Address_width  packed; slice i belongs to master i.
- S_AXI_awlen  in  NUM_MASTERS*S_Aw_len  packed.
- S_AXI_awsize  in  NUM_MASTERS*3  packed.
- S_AXI_awburst  in  NUM_MASTERS*2  packed.
- S_AXI_awlock  in  NUM_MASTERS*2  packed.
- S_AXI_awcache  in  NUM_MASTERS*4  packed.
- S_AXI_awprot  in  NUM_MASTERS*3  packed.
- S_AXI_awqos  in  NUM_MASTERS*4  packed.
- S_AXI_awvalid  in  NUM_MASTERS  per-master valid.
- S_AXI_awready  out  NUM_MASTERS  per-master ready; one-hot or zero.
- M_AXI_awaddr, M_AXI_awlen, M_AXI_awsize, M_AXI_awburst, M_AXI_awlock, M_AXI_awcache, M_AXI_awprot, M_AXI_awqos  out  widths as for one slice  registered payload.
- M_AXI_awvalid  out  1  registered valid.
- M_AXI_awready  in  1  downstream ready.
- M_grant_idx  out  IDX_W  source index of the payload currently held in the output register.
- aw_done  out  1  one-cycle pulse when the downstream handshake completes.
- aw_done_idx  out  IDX_W  source index for that handshake; valid while aw_done=1.

Behaviour:
- Reset (async assert, sync release): M_AXI_awvalid=0; all M_AXI_aw* payload=0; M_grant_idx=0; aw_done=0; aw_done_idx=0; rr_ptr=0; S_AXI_awready=0.
- Definitions:
  - out_free = !M_AXI_awvalid | M_AXI_awready.
  - grant = one-hot winner among S_AXI_awvalid.
  - S_AXI_awready[i] = out_free & grant[i]. This is combinational; awvalid→awready and M_AXI_awready→S_AXI_awready are the only combinational paths.
- Round-robin (ARB_MODE=0):
  - Search starts at rr_ptr and proceeds upward with wrap (NUM_MASTERS-1 → 0).
  - rr_ptr updates to (winner+1) mod NUM_MASTERS only on a master-side accept. No update when the output is stalled.
- Fixed priority (ARB_MODE=1): lowest asserted index wins; rr_ptr is unused and stays 0.
- Load: if out_free and any awvalid, then at the next edge the winner's payload is loaded, M_AXI_awvalid=1 and M_grant_idx=winner. Latency is one cycle from master handshake to M_AXI_awvalid.
- Drain: if M_AXI_awvalid & M_AXI_awready and no awvalid is present, M_AXI_awvalid←0 and the payload holds its last value.
- Back-to-back: a downstream handshake and a new accept in the same cycle give a new payload next cycle with M_AXI_awvalid staying 1, for full throughput of one per cycle.
- Stall: while M_AXI_awvalid & !M_AXI_awready:
  - payload and M_grant_idx are stable;
  - all S_AXI_awready=0;
  - rr_ptr is frozen.
- aw_done and aw_done_idx are registered: on an edge where M_AXI_awvalid & M_AXI_awready, the next cycle has aw_done=1 and aw_done_idx=that M_grant_idx; otherwise aw_done=0.
- Masters may drop awvalid before their accept (non-compliant). The arbiter re-evaluates every cycle; nothing is latched before the accept.
- Reset mid-transaction discards the held payload with no handshake. The downstream side must be reset together with this block.
- Out-of-range index values cannot occur; the rr_ptr wrap uses an explicit compare, not a power-of-2 mask.

Decomposition:
- Shared package axi_ic_pkg holds:
  - the AW field width constants (size 3, burst 2, lock 2, cache 4, prot 3, qos 4);
  - the ARB_MODE encodings ARB_RR=0 and ARB_FIXED=1;
  - a clog2-with-min-1 helper.
- Sub-module rr_arbiter (params N, MODE) contains the combinational one-hot grant plus the rr_ptr register with an advance-enable input. It is reused later by the AR channel.

Test Plan:
- Single master (NUM_MASTERS=4): S1 raises awvalid with awaddr=0x1000_0040, awlen=7, M_AXI_awready=1 → S_AXI_awready=4'b0010 in the same cycle; M_AXI_awvalid=1 with awaddr=0x1000_0040 the next cycle; aw_done=1 with aw_done_idx=1 one cycle after that.
- Round-robin fairness: all four awvalid held, M_AXI_awready=1 → grants appear in the order 0,1,2,3,0,1 on consecutive cycles, with M_AXI_awvalid continuously 1.
- Stall: M_AXI_awready=0 for 5 cycles with S2 and S3 valid → payload is stable, S_AXI_awready=0 throughout, rr_ptr is unchanged. On release, the next grant is the index after the held winner.
- Fixed priority (ARB_MODE=1): S3 and S1 valid continuously → S1 is granted every cycle and S3 is starved until S1 drops.
- Back-to-back with wrap: rr_ptr=3, S3 and S0 valid → order is 3 then 0, with no idle cycle between them.
- Async reset asserted while M_AXI_awvalid=1 and stalled → M_AXI_awvalid=0 immediately (before the next ACLK edge); after release the first grant searches from index 0.
